// File: rtl/clock_step_ctrl.sv
// Core clock controller: HALT / RUN (programmable divisor) / STEP (debounced button).
// Emits a one-cycle tick enable, a legacy slow_clock and a wrapping tick counter.
module clock_step_ctrl #(
  parameter int unsigned DIV_WIDTH = 26,
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned DB_WIDTH  = 20,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 step_btn,
  output logic                 tick,
  output logic                 slow_clock,
  output logic                 running,
  output logic [CNT_WIDTH-1:0] tick_count
);

  typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP} state_t;

  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  sync1_q, sync2_q;
  logic                  db_q, db_d, db_prev_q, rise_q;
  logic [DB_WIDTH-1:0]   db_cnt_q, db_cnt_d;
  logic [DIV_WIDTH-1:0]  per_cnt_q, per_cnt_d;
  logic [DIV_WIDTH-1:0]  nact_q, nact_d;
  logic [DIV_WIDTH-1:0]  div_eff;
  logic                  tick_q, tick_d;
  logic                  slow_q, slow_d;
  logic                  running_q, running_d;
  logic [CNT_WIDTH-1:0]  tick_count_q;

  assign div_eff = (divisor < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : divisor;

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_WIDTH'(1);
      end
    end
  end

  always_comb begin
    unique case (mode)
      2'b01:   state_d = ST_RUN;
      2'b10:   state_d = ST_STEP;
      default: state_d = ST_HALT;
    endcase

    per_cnt_d = '0;
    nact_d    = nact_q;
    if (state_d != state_q) begin
      if (state_d == ST_RUN) nact_d = div_eff;
    end else if (state_q == ST_RUN) begin
      if (per_cnt_q == nact_q - DIV_WIDTH'(1)) begin
        nact_d = div_eff;
      end else begin
        per_cnt_d = per_cnt_q + DIV_WIDTH'(1);
      end
    end

    // Outputs are computed from next-state values so the registered outputs
    // line up with the counter/state they describe; a state change never ticks.
    tick_d    = 1'b0;
    slow_d    = 1'b0;
    running_d = (state_d == ST_RUN);
    unique case (state_d)
      ST_RUN: begin
        tick_d = (state_q == ST_RUN) && (per_cnt_d == nact_d - DIV_WIDTH'(1));
        slow_d = per_cnt_d < (nact_d >> 1);
      end
      ST_STEP: begin
        tick_d = (state_q == ST_STEP) && rise_q;
        slow_d = db_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_HALT;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_q         <= 1'b0;
      db_cnt_q     <= '0;
      db_prev_q    <= 1'b0;
      rise_q       <= 1'b0;
      per_cnt_q    <= '0;
      nact_q       <= '0;
      tick_q       <= 1'b0;
      slow_q       <= 1'b0;
      running_q    <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= step_btn;
      sync2_q      <= sync1_q;
      db_q         <= db_d;
      db_cnt_q     <= db_cnt_d;
      db_prev_q    <= db_q;
      rise_q       <= db_q & ~db_prev_q;
      per_cnt_q    <= per_cnt_d;
      nact_q       <= nact_d;
      tick_q       <= tick_d;
      slow_q       <= slow_d;
      running_q    <= running_d;
      if (tick_q) tick_count_q <= tick_count_q + CNT_WIDTH'(1);
    end
  end

  assign tick       = tick_q;
  assign slow_clock = slow_q;
  assign running    = running_q;
  assign tick_count = tick_count_q;

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Directed bench for clock_step_ctrl with DB_CYCLES=4; a second instance
// with CNT_WIDTH=4 exercises tick_count wrap and asynchronous reset.
module tb_clock_step_ctrl;

  logic        clk = 1'b0;
  logic        rst, btn;
  logic [1:0]  mode;
  logic [7:0]  div;
  logic        tick, slow, run;
  logic [15:0] cnt;

  logic        rst2, btn2;
  logic [1:0]  mode2;
  logic [7:0]  div2;
  logic        tick2, slow2, run2;
  logic [3:0]  cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clock_step_ctrl #(.DIV_WIDTH(8), .DB_CYCLES(4), .DB_WIDTH(3), .CNT_WIDTH(16)) dut (
    .clock(clk), .reset(rst), .mode(mode), .divisor(div), .step_btn(btn),
    .tick(tick), .slow_clock(slow), .running(run), .tick_count(cnt)
  );

  clock_step_ctrl #(.DIV_WIDTH(8), .DB_CYCLES(4), .DB_WIDTH(3), .CNT_WIDTH(4)) dut2 (
    .clock(clk), .reset(rst2), .mode(mode2), .divisor(div2), .step_btn(btn2),
    .tick(tick2), .slow_clock(slow2), .running(run2), .tick_count(cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [7:0] d, input logic b);
    rst = 1'b1; mode = m; div = d; btn = b;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2'b01, 8'd5, 1'b0);
    rst = 1'b1;
    step();
    n_checks++;
    if ({tick, slow, run, cnt} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_state: tick=%b slow=%b run=%b cnt=%0d, want all 0", tick, slow, run, cnt);
    end
    rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step();
      n_checks++;
      if (tick !== (c % 5 == 0) || slow !== ((c - 1) % 5 < 2) || run !== 1'b1 ||
          cnt !== 16'((c - 1) / 5)) begin
        n_fail++;
        $display("FAIL run_div5 c=%0d: tick=%b slow=%b run=%b cnt=%0d, want %b %b 1 %0d",
                 c, tick, slow, run, cnt, (c % 5 == 0), ((c - 1) % 5 < 2), (c - 1) / 5);
      end
    end
  endtask

  task automatic test_divisor_change();
    logic exp_t;
    do_reset(2'b01, 8'd5, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      step();
      exp_t = (c == 5 || c == 8 || c == 11 || c == 14 || c == 16 || c == 18 || c == 20);
      n_checks++;
      if (tick !== exp_t) begin
        n_fail++;
        $display("FAIL div_change c=%0d: tick=%b want %b", c, tick, exp_t);
      end
      if (c == 2)  div = 8'd3;
      if (c == 14) div = 8'd0;
    end
  endtask

  task automatic test_step_single();
    do_reset(2'b10, 8'd5, 1'b0);
    step(); step(); step();
    btn = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step();
      n_checks++;
      if (tick !== (k == 7)) begin
        n_fail++;
        $display("FAIL step_press k=%0d: tick=%b want %b", k, tick, (k == 7));
      end
    end
    n_checks++;
    if (slow !== 1'b1) begin
      n_fail++;
      $display("FAIL step_slow: slow=%b want 1", slow);
    end
    for (int k = 0; k < 100; k++) begin
      step();
      n_checks++;
      if (tick !== 1'b0) begin
        n_fail++;
        $display("FAIL step_hold k=%0d: tick=%b want 0", k, tick);
      end
    end
    n_checks++;
    if (cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL step_count: cnt=%0d want 1", cnt);
    end
  endtask

  task automatic test_glitch();
    btn = 1'b0;
    for (int k = 0; k < 10; k++) step();
    btn = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step();
      if (k == 2) btn = 1'b0;
      n_checks++;
      if (tick !== 1'b0 || slow !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch k=%0d: tick=%b slow=%b want 0 0", k, tick, slow);
      end
    end
    n_checks++;
    if (cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL glitch_count: cnt=%0d want 1", cnt);
    end
  endtask

  task automatic test_mode_switch();
    do_reset(2'b00, 8'd4, 1'b1);
    for (int k = 0; k < 12; k++) step();
    mode = 2'b10;
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if (tick !== 1'b0) begin
        n_fail++;
        $display("FAIL step_entry_held k=%0d: tick=%b want 0", k, tick);
      end
    end
    n_checks++;
    if (slow !== 1'b1 || cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL step_entry_state: slow=%b cnt=%0d want 1 0", slow, cnt);
    end
    mode = 2'b01;
    for (int c = 1; c <= 11; c++) begin
      step();
      n_checks++;
      if (tick !== (c % 4 == 0) || run !== 1'b1) begin
        n_fail++;
        $display("FAIL run_after_step c=%0d: tick=%b run=%b want %b 1", c, tick, run, (c % 4 == 0));
      end
    end
    mode = 2'b10;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (tick !== 1'b0 || run !== 1'b0 || slow !== 1'b1) begin
        n_fail++;
        $display("FAIL pending_tick k=%0d: tick=%b run=%b slow=%b want 0 0 1", k, tick, run, slow);
      end
    end
    mode = 2'b11;
    step(); step();
    n_checks++;
    if (tick !== 1'b0 || slow !== 1'b0 || run !== 1'b0 || cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL mode11: tick=%b slow=%b run=%b cnt=%0d want 0 0 0 2", tick, slow, run, cnt);
    end
  endtask

  task automatic test_wrap_reset();
    rst2 = 1'b1; mode2 = 2'b01; div2 = 8'd2; btn2 = 1'b0;
    step();
    rst2 = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      step();
      n_checks++;
      if (tick2 !== (c % 2 == 0)) begin
        n_fail++;
        $display("FAIL wrap_tick c=%0d: tick=%b want %b", c, tick2, (c % 2 == 0));
      end
      if (c == 31) begin
        n_checks++;
        if (cnt2 !== 4'd15) begin
          n_fail++;
          $display("FAIL wrap_pre: cnt=%0d want 15", cnt2);
        end
      end
      if (c == 33) begin
        n_checks++;
        if (cnt2 !== 4'd0) begin
          n_fail++;
          $display("FAIL wrap_zero: cnt=%0d want 0", cnt2);
        end
      end
    end
    n_checks++;
    if (cnt2 !== 4'd1 || run2 !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_post: cnt=%0d run=%b want 1 1", cnt2, run2);
    end
    #2 rst2 = 1'b1;
    #1;
    n_checks++;
    if ({tick2, slow2, run2, cnt2} !== 7'd0) begin
      n_fail++;
      $display("FAIL async_reset: tick=%b slow=%b run=%b cnt=%0d want all 0", tick2, slow2, run2, cnt2);
    end
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; div = 8'd0; btn = 1'b0;
    rst2 = 1'b1; mode2 = 2'b00; div2 = 8'd0; btn2 = 1'b0;
    test_reset();
    test_divisor_change();
    test_step_single();
    test_glitch();
    test_mode_switch();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
